// File: rtl/allgates_mux2x1_if.sv
// Operand/result bundle for allgates_mux2x1: operands a/b and the seven bitwise gate results y0..y6.
interface allgates_mux2x1_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] y0;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] y2;
   logic [WIDTH-1:0] y3;
   logic [WIDTH-1:0] y4;
   logic [WIDTH-1:0] y5;
   logic [WIDTH-1:0] y6;

   modport master (
      output a, b,
      input  y0, y1, y2, y3, y4, y5, y6
   );

   modport slave (
      input  a, b,
      output y0, y1, y2, y3, y4, y5, y6
   );
endinterface

// File: rtl/allgates_mux2x1.sv
// NOT/AND/OR/NAND/NOR/XOR/XNOR built purely from 2:1 mux cells, registered on clk.
// Define ALLGATES_MUX_COMB_BYPASS_EN to drive the outputs straight from the mux network.
module allgates_mux2x1_cell (
   input  logic sel_i,
   input  logic d0_i,
   input  logic d1_i,
   output logic y_o
);
   assign y_o = sel_i ? d1_i : d0_i;
endmodule

module allgates_mux2x1 #(
   parameter int WIDTH = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   allgates_mux2x1_if.slave  bus
);
   logic [WIDTH-1:0] y0_d, y1_d, y2_d, y3_d, y4_d, y5_d, y6_d;

   // Every cell selects on a[i]; nb is the mux-built inverse of b[i].
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic nb;

      allgates_mux2x1_cell u_nb (.sel_i(bus.b[i]), .d0_i(1'b1),     .d1_i(1'b0),     .y_o(nb));
      allgates_mux2x1_cell u_y0 (.sel_i(bus.a[i]), .d0_i(1'b1),     .d1_i(1'b0),     .y_o(y0_d[i]));
      allgates_mux2x1_cell u_y1 (.sel_i(bus.a[i]), .d0_i(1'b0),     .d1_i(bus.b[i]), .y_o(y1_d[i]));
      allgates_mux2x1_cell u_y2 (.sel_i(bus.a[i]), .d0_i(bus.b[i]), .d1_i(1'b1),     .y_o(y2_d[i]));
      allgates_mux2x1_cell u_y3 (.sel_i(bus.a[i]), .d0_i(1'b1),     .d1_i(nb),       .y_o(y3_d[i]));
      allgates_mux2x1_cell u_y4 (.sel_i(bus.a[i]), .d0_i(nb),       .d1_i(1'b0),     .y_o(y4_d[i]));
      allgates_mux2x1_cell u_y5 (.sel_i(bus.a[i]), .d0_i(bus.b[i]), .d1_i(nb),       .y_o(y5_d[i]));
      allgates_mux2x1_cell u_y6 (.sel_i(bus.a[i]), .d0_i(nb),       .d1_i(bus.b[i]), .y_o(y6_d[i]));
   end

`ifdef ALLGATES_MUX_COMB_BYPASS_EN
   assign bus.y0 = y0_d;
   assign bus.y1 = y1_d;
   assign bus.y2 = y2_d;
   assign bus.y3 = y3_d;
   assign bus.y4 = y4_d;
   assign bus.y5 = y5_d;
   assign bus.y6 = y6_d;
`else
   logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q, y4_q, y5_q, y6_q;

   // Output register stage; reset wins over capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y0_q <= '0;
         y1_q <= '0;
         y2_q <= '0;
         y3_q <= '0;
         y4_q <= '0;
         y5_q <= '0;
         y6_q <= '0;
      end else begin
         y0_q <= y0_d;
         y1_q <= y1_d;
         y2_q <= y2_d;
         y3_q <= y3_d;
         y4_q <= y4_d;
         y5_q <= y5_d;
         y6_q <= y6_d;
      end
   end

   assign bus.y0 = y0_q;
   assign bus.y1 = y1_q;
   assign bus.y2 = y2_q;
   assign bus.y3 = y3_q;
   assign bus.y4 = y4_q;
   assign bus.y5 = y5_q;
   assign bus.y6 = y6_q;
`endif
endmodule

// File: tb/tb_allgates_mux2x1.sv
// Bench for allgates_mux2x1: directed sequence plus random operands at WIDTH=1 and WIDTH=4.
module tb_allgates_mux2x1;
   logic clk = 1'b0;
   logic rst_n;
   int   n_asserts = 0;
   int   n_fail    = 0;

   allgates_mux2x1_if #(.WIDTH(1)) bus1 ();
   allgates_mux2x1_if #(.WIDTH(4)) bus4 ();

   allgates_mux2x1 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   allgates_mux2x1 #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

   always #5 clk = ~clk;

   // Reference: results packed as {y6,y5,y4,y3,y2,y1,y0}.
   function automatic logic [6:0] ref1(input logic a, input logic b);
      return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
   endfunction

   function automatic logic [27:0] ref4(input logic [3:0] a, input logic [3:0] b);
      return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
   endfunction

   function automatic logic [6:0] obs1();
      return {bus1.y6, bus1.y5, bus1.y4, bus1.y3, bus1.y2, bus1.y1, bus1.y0};
   endfunction

   function automatic logic [27:0] obs4();
      return {bus4.y6, bus4.y5, bus4.y4, bus4.y3, bus4.y2, bus4.y1, bus4.y0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0]  tt [4];
      logic [27:0] w4_exp;
      logic [3:0]  ra, rb;
      logic        r1a, r1b;
      tt[0] = 7'b1011001;
      tt[1] = 7'b0101101;
      tt[2] = 7'b0101100;
      tt[3] = 7'b1000110;

`ifdef ALLGATES_MUX_COMB_BYPASS_EN
      rst_n  = 1'b0;
      bus1.a = 1'b1; bus1.b = 1'b0;
      bus4.a = 4'b1100; bus4.b = 4'b1010;
      #1;
      check("byp_y5", {31'd0, bus1.y5}, 32'd1);
      check("byp_w1_all", {25'd0, obs1()}, {25'd0, ref1(1'b1, 1'b0)});
      check("byp_w4_all", {4'd0, obs4()}, {4'd0, ref4(4'b1100, 4'b1010)});
      for (int i = 0; i < 4; i++) begin
         bus1.a = i[1]; bus1.b = i[0];
         #1;
         check($sformatf("byp_tt%0d", i), {25'd0, obs1()}, {25'd0, tt[i]});
      end
      for (int i = 0; i < 20; i++) begin
         rst_n  = 1'($urandom_range(0, 1));
         r1a = 1'($urandom); r1b = 1'($urandom);
         ra  = 4'($urandom); rb  = 4'($urandom);
         bus1.a = r1a; bus1.b = r1b; bus4.a = ra; bus4.b = rb;
         #2;
         check("byp_rand_w1", {25'd0, obs1()}, {25'd0, ref1(r1a, r1b)});
         check("byp_rand_w4", {4'd0, obs4()}, {4'd0, ref4(ra, rb)});
      end
`else
      rst_n  = 1'b0;
      bus1.a = 1'b1; bus1.b = 1'b1;
      bus4.a = 4'hF; bus4.b = 4'hF;
      edge_sample();
      edge_sample();
      check("reset_w1", {25'd0, obs1()}, 32'd0);
      check("reset_w4", {4'd0, obs4()}, 32'd0);

      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus1.a = i[1]; bus1.b = i[0];
         edge_sample();
         check($sformatf("tt%0d", i), {25'd0, obs1()}, {25'd0, tt[i]});
      end

      // Latency: a rises mid-cycle, y1 must hold until the next edge.
      bus1.a = 1'b0; bus1.b = 1'b1;
      edge_sample();
      check("lat_y1_before", {31'd0, bus1.y1}, 32'd0);
      #3;
      bus1.a = 1'b1;
      #1;
      check("lat_y1_midcycle", {31'd0, bus1.y1}, 32'd0);
      edge_sample();
      check("lat_y1_after", {31'd0, bus1.y1}, 32'd1);

      bus1.a = 1'b1; bus1.b = 1'b0;
      edge_sample();
      check("mid_valid", {25'd0, obs1()}, {25'd0, ref1(1'b1, 1'b0)});
      rst_n = 1'b0;
      edge_sample();
      check("mid_reset", {25'd0, obs1()}, 32'd0);
      rst_n = 1'b1;
      edge_sample();
      check("mid_rel_y2", {31'd0, bus1.y2}, 32'd1);
      check("mid_rel_y5", {31'd0, bus1.y5}, 32'd1);

      bus4.a = 4'b1100; bus4.b = 4'b1010;
      edge_sample();
      check("w4_y0", {28'd0, bus4.y0}, 32'b0011);
      check("w4_y1", {28'd0, bus4.y1}, 32'b1000);
      check("w4_y2", {28'd0, bus4.y2}, 32'b1110);
      check("w4_y3", {28'd0, bus4.y3}, 32'b0111);
      check("w4_y4", {28'd0, bus4.y4}, 32'b0001);
      check("w4_y5", {28'd0, bus4.y5}, 32'b0110);
      check("w4_y6", {28'd0, bus4.y6}, 32'b1001);

      for (int i = 0; i < 40; i++) begin
         rst_n = ($urandom_range(0, 7) != 0);
         r1a = 1'($urandom); r1b = 1'($urandom);
         ra  = 4'($urandom); rb  = 4'($urandom);
         bus1.a = r1a; bus1.b = r1b; bus4.a = ra; bus4.b = rb;
         w4_exp = rst_n ? ref4(ra, rb) : 28'd0;
         edge_sample();
         check("rand_w1", {25'd0, obs1()}, {25'd0, (rst_n ? ref1(r1a, r1b) : 7'd0)});
         check("rand_w4", {4'd0, obs4()}, {4'd0, w4_exp});
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule

// File: doc/allgates_mux2x1.md
Name: allgates_mux2x1

Overview:
- Gate-library demonstrator: the seven basic 2-input/1-input logic functions of operands a and b, each built only from 2:1 multiplexer cells.
- Results are registered on one clock.
- Sits as a leaf block; operands may be scaled to WIDTH-bit vectors evaluated bitwise.

Parameters:
- WIDTH, 1, bit width of a, b and every y output; all functions bitwise per bit position.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a  input  WIDTH  operand A (select input of every mux cell)
- b  input  WIDTH  operand B
- y0  output  WIDTH  NOT a
- y1  output  WIDTH  a AND b
- y2  output  WIDTH  a OR b
- y3  output  WIDTH  a NAND b
- y4  output  WIDTH  a NOR b
- y5  output  WIDTH  a XOR b
- y6  output  WIDTH  a XNOR b

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Mux cell: a separate 1-bit 2:1 mux submodule, out = sel ? d1 : d0. It is instantiated per bit via generate.
- No gate operators (&, |, ^, ~) are used in the function datapath. Constants 0/1 and mux outputs are the only permitted data sources.
- Per-bit mux mapping (sel = a[i] in every case; nb = NOT b, itself a mux with sel=b, d0=1, d1=0):
  - y0: d0=1, d1=0
  - y1: d0=0, d1=b
  - y2: d0=b, d1=1
  - y3: d0=1, d1=nb
  - y4: d0=nb, d1=0
  - y5: d0=b, d1=nb
  - y6: d0=nb, d1=b
- Registering: the seven combinational results are captured on each rising clk edge into output registers y0..y6.
  - Latency: exactly 1 cycle from a/b change (settled before the edge) to the outputs.
  - No handshake; a new result is produced every cycle.
- Reset: when rst_n=0 at a rising edge, all outputs go to 0 (every bit of y0..y6). Reset has priority over capture.
  - Reset asserted mid-stream clears outputs at that edge.
  - The first capture after release reflects a/b present at that edge.
- No internal state beyond the output registers; no FSM.
- X/Z on a select propagates per simulator mux semantics; no special handling.
- Bits are independent; no carries or cross-bit interaction.

Optional Feature:
- Macro ALLGATES_MUX_COMB_BYPASS_EN.
- Defined: y0..y6 are driven directly by the mux network (zero latency, purely combinational). clk and rst_n remain ports but are unused; the reset has no effect.
- Undefined (default): registered behaviour as above.

Test Plan:
- Reset: rst_n=0 for 2 cycles with a=1, b=1 -> all y outputs 0 after the edge.
- Truth table (WIDTH=1, rst_n=1): sweep {a,b}=00,01,10,11, one per cycle. One cycle later, y0..y6 respectively:
  - 00 -> 1,0,0,1,1,0,1
  - 01 -> 1,0,1,1,0,1,0
  - 10 -> 0,0,1,1,0,1,0
  - 11 -> 0,1,1,0,0,0,1
- Latency: change a from 0 to 1 with b=1 mid-cycle -> y1 stays 0 until the next rising edge, then becomes 1.
- Reset mid-stream: a=1, b=0 with outputs valid, drop rst_n for one edge -> all outputs 0; on release, y2=1 and y5=1 one edge later.
- WIDTH=4: a=4'b1100, b=4'b1010 -> y1=1000, y2=1110, y3=0111, y4=0001, y5=0110, y6=1001, y0=0011.
- Bypass build (ALLGATES_MUX_COMB_BYPASS_EN): a=1, b=0 with no clock edge -> y5=1 within delta time; rst_n=0 does not clear the outputs.
